// File: rtl/waterfall_pkg.sv
// Shared encodings for the waterfall-light sequencer: 194 mode selects, FSM states,
// run modes and the direction-update helper used at each shift step.
package waterfall_pkg;

  localparam logic [1:0] MODE_HOLD = 2'b00;
  localparam logic [1:0] MODE_SHR  = 2'b01;
  localparam logic [1:0] MODE_SHL  = 2'b10;
  localparam logic [1:0] MODE_LOAD = 2'b11;

  typedef enum logic [1:0] {IDLE, CLEAR, LOAD, RUN} state_t;
  typedef enum logic [1:0] {RUN_R, RUN_L, RUN_BOUNCE} run_mode_t;
  typedef enum logic {DIR_R, DIR_L} dir_t;

  // The reserved code 11 behaves like rotate-right.
  function automatic run_mode_t decode_mode(input logic [1:0] m);
    run_mode_t rm;
    case (m)
      2'b01:   rm = RUN_L;
      2'b10:   rm = RUN_BOUNCE;
      default: rm = RUN_R;
    endcase
    return rm;
  endfunction

  // Bounce reverses only when the lit bit sits at the end it is moving towards.
  function automatic dir_t step_dir(input run_mode_t rm, input dir_t cur, input logic [7:0] q);
    dir_t nd;
    nd = cur;
    case (rm)
      RUN_L: nd = DIR_L;
      RUN_BOUNCE: begin
        if (cur == DIR_R && q == 8'h01)
          nd = DIR_L;
        else if (cur == DIR_L && q == 8'h80)
          nd = DIR_R;
      end
      default: nd = DIR_R;
    endcase
    return nd;
  endfunction

endpackage

// File: rtl/waterfall_tick_div.sv
// Step-rate divider: free-running counter with clear, flagging the terminal count.
// With WATERFALL_SPEED_SEL_EN the terminal count follows speed, sampled on clear and at each step.
module waterfall_tick_div
  import waterfall_pkg::*;
#(
  parameter int DIV = 5_000_000,
  parameter int CW  = 23
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       clr,
  input  logic       en,
`ifdef WATERFALL_SPEED_SEL_EN
  input  logic [1:0] speed,
`endif
  output logic       term
);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] tc_q;

`ifdef WATERFALL_SPEED_SEL_EN
  function automatic logic [CW-1:0] calc_tc(input logic [1:0] sp);
    int t;
    t = (DIV >> sp) - 1;
    if (t < 1)
      t = 1;
    return CW'(t);
  endfunction

  // Latching speed only at step boundaries keeps a step in progress from being cut short.
  always_ff @(posedge clk) begin
    if (rst)
      tc_q <= CW'(DIV - 1);
    else if (clr || (en && term))
      tc_q <= calc_tc(speed);
  end
`else
  assign tc_q = CW'(DIV - 1);
`endif

  assign term = (cnt_q == tc_q);

  always_ff @(posedge clk) begin
    if (rst)
      cnt_q <= '0;
    else if (clr)
      cnt_q <= '0;
    else if (en)
      cnt_q <= term ? '0 : cnt_q + CW'(1);
  end

endmodule

// File: rtl/waterfall_ctrl.sv
// Sequencing master for the 194-style shift register: clear, seed, then rotate/bounce steps.
// Optional speed select input is enabled by defining WATERFALL_SPEED_SEL_EN.
module waterfall_ctrl
  import waterfall_pkg::*;
#(
  parameter int          DIV     = 5_000_000,
  parameter logic [7:0]  PATTERN = 8'b1000_0000,
  parameter int          CW      = 23
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       stop,
  input  logic [1:0] mode,
  input  logic [7:0] Q,
`ifdef WATERFALL_SPEED_SEL_EN
  input  logic [1:0] speed,
`endif
  output logic       S1,
  output logic       S0,
  output logic       CR,
  output logic       clr_n,
  output logic [7:0] D,
  output logic       busy,
  output logic       tick
);

  state_t     state_q, state_d;
  dir_t       dir_q, dir_d, new_dir;
  logic [1:0] s1s0_q, s1s0_d;
  logic       cr_q, cr_d;
  logic       clr_n_q, clr_n_d;
  logic [7:0] d_q, d_d;
  logic       busy_q;
  logic       tick_q, tick_d;
  logic       cnt_clr, cnt_en, term, step;

  waterfall_tick_div #(
    .DIV (DIV),
    .CW  (CW)
  ) u_div (
    .clk   (clk),
    .rst   (rst),
    .clr   (cnt_clr),
    .en    (cnt_en),
`ifdef WATERFALL_SPEED_SEL_EN
    .speed (speed),
`endif
    .term  (term)
  );

  // Outputs are decoded from the next state so every port comes straight from a flop.
  always_comb begin
    state_d = state_q;
    s1s0_d  = MODE_HOLD;
    cr_d    = 1'b0;
    clr_n_d = 1'b0;
    d_d     = d_q;
    tick_d  = 1'b0;
    dir_d   = dir_q;
    cnt_clr = 1'b0;
    cnt_en  = 1'b0;
    step    = (state_q == RUN) && term;
    new_dir = step_dir(decode_mode(mode), dir_q, Q);

    if (stop)
      state_d = IDLE;
    else if (start)
      state_d = CLEAR;
    else begin
      case (state_q)
        CLEAR:   state_d = LOAD;
        LOAD:    state_d = RUN;
        RUN:     if (step && Q == 8'h00) state_d = LOAD;
        default: state_d = state_q;
      endcase
    end

    case (state_d)
      CLEAR: cr_d = 1'b1;
      LOAD: begin
        s1s0_d  = MODE_LOAD;
        d_d     = PATTERN;
        clr_n_d = 1'b1;
        cr_d    = 1'b1;
        cnt_clr = 1'b1;
        dir_d   = (decode_mode(mode) == RUN_L) ? DIR_L : DIR_R;
      end
      RUN: begin
        cr_d    = 1'b1;
        clr_n_d = 1'b1;
        cnt_en  = 1'b1;
        if (step) begin
          tick_d = 1'b1;
          dir_d  = new_dir;
          s1s0_d = (new_dir == DIR_L) ? MODE_SHL : MODE_SHR;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      dir_q   <= DIR_R;
      s1s0_q  <= MODE_HOLD;
      cr_q    <= 1'b0;
      clr_n_q <= 1'b0;
      d_q     <= 8'h00;
      busy_q  <= 1'b0;
      tick_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      dir_q   <= dir_d;
      s1s0_q  <= s1s0_d;
      cr_q    <= cr_d;
      clr_n_q <= clr_n_d;
      d_q     <= d_d;
      busy_q  <= (state_d != IDLE);
      tick_q  <= tick_d;
    end
  end

  assign S1    = s1s0_q[1];
  assign S0    = s1s0_q[0];
  assign CR    = cr_q;
  assign clr_n = clr_n_q;
  assign D     = d_q;
  assign busy  = busy_q;
  assign tick  = tick_q;

endmodule

// File: tb/tb_waterfall_ctrl.sv
// Bench for waterfall_ctrl driving a behavioural 194 model whose Q feeds back.
// Expected shift steps are queued at start and popped as the controller issues ticks.
module tb_waterfall_ctrl;
  import waterfall_pkg::*;

  localparam int TB_DIV = 4;

  logic       clk = 1'b0;
  logic       rst, start, stop;
  logic [1:0] mode;
  logic [7:0] q;
  logic       S1, S0, CR, clr_n, busy, tick;
  logic [7:0] D;
  logic       force_zero;
`ifdef WATERFALL_SPEED_SEL_EN
  logic [1:0] speed;
`endif

  typedef struct packed {
    logic [1:0] s1s0;
    logic [7:0] q;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc    = 0;
  int   last   = 0;

  waterfall_ctrl #(
    .DIV     (TB_DIV),
    .PATTERN (8'h80),
    .CW      (3)
  ) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .stop  (stop),
    .mode  (mode),
    .Q     (q),
`ifdef WATERFALL_SPEED_SEL_EN
    .speed (speed),
`endif
    .S1    (S1),
    .S0    (S0),
    .CR    (CR),
    .clr_n (clr_n),
    .D     (D),
    .busy  (busy),
    .tick  (tick)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // 194 model; serial inputs wired back so shifts rotate.
  always @(posedge clk) begin
    if (force_zero)
      q <= 8'h00;
    else if (!clr_n)
      q <= 8'h00;
    else if (CR) begin
      case ({S1, S0})
        2'b01:   q <= {q[0], q[7:1]};
        2'b10:   q <= {q[6:0], q[7]};
        2'b11:   q <= D;
        default: ;
      endcase
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic push_step(input logic [1:0] cmd, input logic [7:0] qv);
    exp_t e;
    e.s1s0 = cmd;
    e.q    = qv;
    sb.push_back(e);
  endtask

  task automatic do_start(input logic [1:0] m);
    mode  = m;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("clear_clr_n", 32'(clr_n), 32'd0);
    chk("clear_cr", 32'(CR), 32'd1);
    chk("clear_busy", 32'(busy), 32'd1);
    chk("clear_hold", 32'({S1, S0}), 32'(MODE_HOLD));
    @(negedge clk);
    chk("load_cmd", 32'({S1, S0}), 32'(MODE_LOAD));
    chk("load_d", 32'(D), 32'h80);
    chk("load_clr_n", 32'(clr_n), 32'd1);
    last = cyc;
  endtask

  task automatic run_ticks(input int n, input int per);
    for (int k = 0; k < n; k++) begin
      int   found;
      int   bad;
      exp_t e;
      found = 0;
      bad   = 0;
      for (int w = 0; w < 3 * per + 4 && found == 0; w++) begin
        @(negedge clk);
        if (tick)
          found = 1;
        else if ({S1, S0} != MODE_HOLD)
          bad++;
      end
      chk("tick_seen", 32'(found), 32'd1);
      chk("hold_between", 32'(bad), 32'd0);
      if (sb.size() == 0)
        chk("sb_nonempty", 32'(sb.size()), 32'd1);
      else begin
        e = sb.pop_front();
        if (found == 1) begin
          chk("tick_period", 32'(cyc - last), 32'(per));
          chk("shift_cmd", 32'({S1, S0}), 32'(e.s1s0));
          chk("q_seq", 32'(q), 32'(e.q));
        end
      end
      last = cyc;
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int found;
    int nt;
    logic [7:0] seed;
    seed       = 8'h80;
    rst        = 1'b1;
    start      = 1'b0;
    stop       = 1'b0;
    mode       = 2'b00;
    force_zero = 1'b0;
`ifdef WATERFALL_SPEED_SEL_EN
    speed      = 2'b00;
`endif
    repeat (3) @(negedge clk);
    chk("rst_outputs", 32'({S1, S0, CR, clr_n, busy, tick}), 32'd0);
    chk("rst_d", 32'(D), 32'd0);
    rst = 1'b0;
    repeat (6) @(negedge clk);
    chk("idle_busy", 32'(busy), 32'd0);

    // rotate right, including the 01 -> 80 wrap
    for (int i = 0; i < 10; i++)
      push_step(MODE_SHR, seed >> (i % 8));
    do_start(2'b00);
    run_ticks(10, TB_DIV);

    // bounce, restarted from RUN
    for (int i = 0; i < 7; i++)
      push_step(MODE_SHR, seed >> i);
    for (int i = 0; i < 7; i++)
      push_step(MODE_SHL, 8'(8'h01 << i));
    push_step(MODE_SHR, 8'h80);
    push_step(MODE_SHR, 8'h40);
    do_start(2'b10);
    run_ticks(16, TB_DIV);

    // pattern loss: Q forced to 00 just after a step
    push_step(MODE_SHR, 8'h80);
    push_step(MODE_SHR, 8'h40);
    push_step(MODE_SHR, 8'h20);
    do_start(2'b00);
    run_ticks(3, TB_DIV);
    force_zero = 1'b1;
    @(negedge clk);
    force_zero = 1'b0;
    found = 0;
    for (int w = 0; w < 3 * TB_DIV && found == 0; w++) begin
      if ({S1, S0} == MODE_LOAD)
        found = 1;
      else
        @(negedge clk);
    end
    chk("reseed_seen", 32'(found), 32'd1);
    chk("reseed_gap", 32'(cyc - last), 32'(TB_DIV));
    chk("reseed_d", 32'(D), 32'h80);
    chk("reseed_tick", 32'(tick), 32'd0);
    last = cyc;
    push_step(MODE_SHR, 8'h80);
    push_step(MODE_SHR, 8'h40);
    run_ticks(2, TB_DIV);

    // stop and start together: stop wins
    @(negedge clk);
    stop  = 1'b1;
    start = 1'b1;
    @(negedge clk);
    stop  = 1'b0;
    start = 1'b0;
    chk("stop_cr", 32'(CR), 32'd0);
    chk("stop_busy", 32'(busy), 32'd0);
    chk("stop_hold", 32'({S1, S0}), 32'(MODE_HOLD));
    nt = 0;
    repeat (3 * TB_DIV) begin
      @(negedge clk);
      if (tick || busy)
        nt++;
    end
    chk("stop_stays_idle", 32'(nt), 32'd0);

    // reset landing on a tick cycle
    push_step(MODE_SHR, 8'h80);
    do_start(2'b00);
    run_ticks(1, TB_DIV);
    rst = 1'b1;
    @(negedge clk);
    chk("rst_mid_outputs", 32'({S1, S0, CR, clr_n, busy, tick}), 32'd0);
    chk("rst_mid_d", 32'(D), 32'd0);
    rst = 1'b0;
    @(negedge clk);

`ifdef WATERFALL_SPEED_SEL_EN
    speed = 2'b01;
    push_step(MODE_SHR, 8'h80);
    push_step(MODE_SHR, 8'h40);
    push_step(MODE_SHR, 8'h20);
    do_start(2'b00);
    run_ticks(3, TB_DIV / 2);
`endif

    chk("sb_empty", 32'(sb.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/waterfall_ctrl.md
Name: waterfall_ctrl

Overview:
- Sequencing master for the 8-bit 194-style shift register (shift_register_8) in the FPGA waterfall-light design.
- Generates S1/S0 mode select, CR enable, clr_n clear and parallel-load data D.
- Reads the register's Q back to run right, left or bounce (ping-pong) patterns at a divided tick rate.
- Sits between the board-level buttons/switches and shift_register_8; both blocks share one clock.

Parameters:
- DIV, 5_000_000: clk cycles per shift step; must be ≥ 2.
- PATTERN, 8'b1000_0000: seed value parallel-loaded on start.
- CW, 23: width of the tick counter; must satisfy 2**CW ≥ DIV.

Ports:
- clk  in  1  system clock, shared with shift_register_8's CP.
- rst  in  1  synchronous active-high reset.
- start  in  1  one-cycle pulse; begins or restarts a run.
- stop  in  1  one-cycle pulse; returns to idle.
- mode  in  2  00 rotate right, 01 rotate left, 10 bounce, 11 reserved (treated as 00).
- Q  in  8  register output feedback.
- S1  out  1  register mode select, high bit.
- S0  out  1  register mode select, low bit.
- CR  out  1  register enable; 1 while running.
- clr_n  out  1  register clear, active-low.
- D  out  8  parallel-load data.
- busy  out  1  high in every state except IDLE.
- tick  out  1  one-cycle strobe marking each shift step.

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous and active-high (rst).
- Reset values: state=IDLE, S1=0, S0=0, CR=0, clr_n=0, D=8'h00, busy=0, tick=0, counter=0, dir=right.
- Register mode encoding: S1S0 = 00 hold, 01 shift right, 10 shift left, 11 parallel load.
- All outputs are registered.
- IDLE:
  - S1S0=00, CR=0, clr_n=0.
  - start → CLEAR.
- CLEAR (1 cycle):
  - clr_n=0, CR=1.
  - → LOAD.
- LOAD (1 cycle):
  - S1S0=11, D=PATTERN, clr_n=1, CR=1.
  - Counter cleared.
  - dir = left if mode=01, otherwise right.
  - → RUN.
- RUN:
  - Counter increments each cycle.
  - When counter = DIV-1: tick=1, counter=0, and S1S0=01 (dir right) or 10 (dir left) for exactly that cycle.
  - All other cycles: S1S0=00.
- Latency:
  - start sampled at cycle n → clr_n low at n+1, load at n+2.
  - First shift command at n+2+DIV.
- Bounce (mode=10), evaluated on the Q value sampled in the tick cycle:
  - dir right and Q=8'h01 → dir=left, and that tick issues shift left.
  - dir left and Q=8'h80 → dir=right, and that tick issues shift right.
- Mode change during RUN:
  - Takes effect at the next tick.
  - 00 forces dir=right; 01 forces dir=left; 10 keeps the current dir.
- Pattern-loss recovery: Q=8'h00 sampled at a tick in RUN → LOAD next cycle (reseed); no shift issued that tick.
- stop:
  - In any non-IDLE state → IDLE next cycle, with S1S0=00 and CR=0.
  - stop has priority over start when both arrive in the same cycle.
- start in RUN/CLEAR/LOAD: restarts at CLEAR.
- rst mid-run: all outputs return to reset values on the next edge, regardless of state.

Optional Feature:
- Macro WATERFALL_SPEED_SEL_EN.
- When defined:
  - Adds input speed[1:0].
  - Tick terminal count = (DIV >> speed) - 1, with a minimum of 1.
  - speed is sampled only at LOAD and at each tick, so a step in progress is never truncated.
- When undefined: no speed port; terminal count = DIV-1.

Decomposition:
- Package waterfall_pkg holds:
  - S1S0 mode localparams: MODE_HOLD=2'b00, MODE_SHR=2'b01, MODE_SHL=2'b10, MODE_LOAD=2'b11.
  - State encoding: IDLE, CLEAR, LOAD, RUN.
  - Run-mode codes: RUN_R, RUN_L, RUN_BOUNCE.
- One sub-module, waterfall_tick_div:
  - Parameterised counter with clear input and tick output.
  - Under WATERFALL_SPEED_SEL_EN it also takes the speed input.

Test Plan (all with DIV=4, PATTERN=8'h80, the controller driving a behavioural 194 model that feeds Q back):
- rst held 3 cycles → all outputs at reset values, busy=0, S1S0=00.
- start at cycle 10, mode=00 →
  - clr_n=0 at 11; S1S0=11 with D=80 at 12.
  - S1S0=01 with tick=1 at 16, 20, 24, …
  - Q sequence: 80, 40, 20, … then 01 → 80 (rotate).
- mode=10 →
  - Q: 80, 40, …, 01, then 02, 04, …, 80, then 40 (reverses at each end).
  - No hold-only or double-shift glitch at the turnaround.
- Force Q=00 via the model in RUN → next tick triggers LOAD (S1S0=11, D=80), then normal stepping resumes.
- stop and start pulsed in the same cycle during RUN → IDLE next cycle, CR=0, busy=0.
- rst asserted mid-RUN at a tick cycle → next edge: S1S0=00, clr_n=0, state IDLE.
- With WATERFALL_SPEED_SEL_EN and speed=1 → tick period 2 cycles.
